rr_fifo_merger: RTL and testbench
=================================

Name: rr_fifo_merger

Overview:
- Merges N first-word-fall-through (FWFT) data sources into one FWFT 32-bit stream.
- The sources are front-end receiver FIFOs. The output feeds the SRAM-backed output FIFO through FIFO_DATA, FIFO_EMPTY_OUT and FIFO_READ_NEXT_IN.
- Arbitration is round-robin with a bounded burst per grant, so one source cannot starve the others.
- A single output register decouples the sources from the consumer and sustains 1 word/cycle.

Parameters:
N_SRC, 4, number of input sources (1..16).
MAX_BURST, 16, maximum consecutive words taken from one source per grant (1..256).

Ports:
BUS_CLK  input  1  clock; all logic on posedge.
RST  input  1  synchronous, active-high reset.
SRC_DATA  input  32*N_SRC  source i data at bits [32*i+31:32*i]; valid when SRC_EMPTY[i]=0.
SRC_EMPTY  input  N_SRC  source i has no word.
SRC_READ  output  N_SRC  pop strobe to source i; one-hot or zero.
FIFO_READ_NEXT_IN  input  1  consumer pops the current output word.
FIFO_EMPTY_OUT  output  1  output register holds no valid word.
FIFO_DATA  output  32  current output word; valid when FIFO_EMPTY_OUT=0.
CUR_SRC  output  4  index of the currently granted source; valid in GRANT.
WORD_COUNT  output  32  total words delivered to the consumer; saturates at 32'hFFFF_FFFF.
READ_ERROR  output  1  sticky flag: FIFO_READ_NEXT_IN was seen while FIFO_EMPTY_OUT=1.

Behaviour:
- Reset values:
  - SRC_READ=0, FIFO_EMPTY_OUT=1, FIFO_DATA=0, CUR_SRC=0, WORD_COUNT=0, READ_ERROR=0.
  - FSM=IDLE, last-served pointer=N_SRC-1, so source 0 is checked first.
  - Burst counter=0.
- Output register:
  - out_free = FIFO_EMPTY_OUT | FIFO_READ_NEXT_IN.
  - A source word is popped only when out_free=1 and the FSM is in GRANT with SRC_EMPTY[CUR_SRC]=0.
  - Pop means SRC_READ[CUR_SRC]=1 combinationally, and FIFO_DATA<=SRC_DATA word on the same edge.
  - FIFO_EMPTY_OUT<=0 on that edge.
  - If the consumer pops and no load occurs, FIFO_EMPTY_OUT<=1. FIFO_DATA holds its stale value.
- Latency: a source word reaches FIFO_DATA 1 cycle after its SRC_READ. Sustained throughput is 1 word/cycle with a simultaneous pop and load.
- FSM states:
  - IDLE: scan sources cyclically starting at last+1 and take the first with SRC_EMPTY=0. On a hit, CUR_SRC<=index, burst<=0, go to GRANT. With no requests, stay in IDLE. The scan is combinational priority over all N_SRC and takes 1 cycle.
  - GRANT: each pop increments burst. Leave to IDLE with last<=CUR_SRC when either:
    - the pop that makes burst==MAX_BURST occurs, or
    - SRC_EMPTY[CUR_SRC]=1 in a cycle where out_free=1.
  - The transition cycle itself issues no SRC_READ, giving 1 bubble per grant change.
  - Source empty while out_free=0: remain in GRANT, keeping the grant while the consumer stalls.
- With only one source active, it is re-granted after each bubble. Effective rate is MAX_BURST/(MAX_BURST+1).
- SRC_READ is never asserted while the selected SRC_EMPTY=1. At most one SRC_READ bit is high in any cycle.
- WORD_COUNT increments on FIFO_READ_NEXT_IN & !FIFO_EMPTY_OUT and saturates at all-ones.
- READ_ERROR is set on FIFO_READ_NEXT_IN & FIFO_EMPTY_OUT. A read while empty does not change the output register. READ_ERROR clears only on RST.
- Reset mid-burst: all state returns to reset values on the next edge. A word held in the output register is discarded, and no SRC_READ is issued in the RST cycle.
- Index arithmetic: the pointer wraps from N_SRC-1 to 0. Width is 4 bits, zero-extended onto CUR_SRC.

Decomposition:
- Package rr_fifo_merger_pkg:
  - FSM state enum: IDLE=0, GRANT=1.
  - Constant SRC_IDX_W=4.
  - Function next_rr(req, last, n) returns the first requesting index after last, with wrap.
- Sub-module rr_pick (combinational round-robin picker: req vector + last index -> grant index + hit). This is natural and separately testable.
- The FSM, output register and counters stay in the top module.

Test Plan:
- Reset, then source 2 alone holds 3 words A,B,C with the consumer always reading. Required: FIFO_DATA shows A,B,C on consecutive cycles, the first 2 cycles after SRC_EMPTY[2] falls; WORD_COUNT=3; FIFO_EMPTY_OUT=1 afterwards.
- MAX_BURST=4, sources 0 and 1 each continuously non-empty. Required: output source sequence 0,0,0,0,1,1,1,1,0… with exactly 1 empty-output cycle between bursts.
- Consumer holds FIFO_READ_NEXT_IN=0 for 10 cycles with 5 words pending. Required: FIFO_DATA stable on the first word, no SRC_READ while the register is full, no word lost or duplicated after release.
- All sources empty, consumer pulses FIFO_READ_NEXT_IN. Required: READ_ERROR=1, WORD_COUNT unchanged; READ_ERROR=0 only after RST.
- Assert RST during the 2nd word of a burst from source 3. Required: the next cycle shows FIFO_EMPTY_OUT=1, SRC_READ=0, WORD_COUNT=0; the first grant after reset goes to the lowest-index non-empty source.
- Preload WORD_COUNT near 32'hFFFF_FFFE via a force, then deliver 3 words. Required: the count saturates at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/rr_fifo_merger_pkg.sv
// Shared types and helpers for the round-robin FIFO merger.
package rr_fifo_merger_pkg;

   localparam int unsigned SRC_IDX_W = 4;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned MAX_SRC   = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   typedef struct packed {
      logic                 hit;
      logic [SRC_IDX_W-1:0] idx;
   } pick_t;

   // First requesting index after 'last', wrapping at n; indices past n are
   // revisits and never change an earlier hit.
   function automatic pick_t next_rr(input logic [MAX_SRC-1:0]   req,
                                     input logic [SRC_IDX_W-1:0] last,
                                     input int unsigned          n);
      pick_t                res;
      int unsigned          cand;
      logic [SRC_IDX_W-1:0] cand_idx;
      res = '0;
      for (int unsigned k = 1; k <= MAX_SRC; k++) begin
         cand     = (32'(last) + k) % n;
         cand_idx = SRC_IDX_W'(cand);
         if (!res.hit && req[cand_idx]) begin
            res.hit = 1'b1;
            res.idx = cand_idx;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_fifo_merger_if.sv
// Source-side and consumer-side signals of the FIFO merger.
interface rr_fifo_merger_if
   import rr_fifo_merger_pkg::*;
#(
   parameter int unsigned N_SRC = 4
);

   logic [DATA_W*N_SRC-1:0] SRC_DATA;
   logic [N_SRC-1:0]        SRC_EMPTY;
   logic [N_SRC-1:0]        SRC_READ;
   logic                    FIFO_READ_NEXT_IN;
   logic                    FIFO_EMPTY_OUT;
   logic [DATA_W-1:0]       FIFO_DATA;
   logic [SRC_IDX_W-1:0]    CUR_SRC;
   logic [31:0]             WORD_COUNT;
   logic                    READ_ERROR;

   modport master (
      input  SRC_DATA,
      input  SRC_EMPTY,
      input  FIFO_READ_NEXT_IN,
      output SRC_READ,
      output FIFO_EMPTY_OUT,
      output FIFO_DATA,
      output CUR_SRC,
      output WORD_COUNT,
      output READ_ERROR
   );

   modport slave (
      output SRC_DATA,
      output SRC_EMPTY,
      output FIFO_READ_NEXT_IN,
      input  SRC_READ,
      input  FIFO_EMPTY_OUT,
      input  FIFO_DATA,
      input  CUR_SRC,
      input  WORD_COUNT,
      input  READ_ERROR
   );

endinterface

// File: rtl/rr_fifo_merger_rr_pick.sv
// Combinational round-robin picker: request vector plus last-served index
// gives the next index to grant.
module rr_pick
   import rr_fifo_merger_pkg::*;
#(
   parameter int unsigned N_SRC = 4
) (
   input  logic [N_SRC-1:0]     req_i,
   input  logic [SRC_IDX_W-1:0] last_i,
   output logic [SRC_IDX_W-1:0] grant_o,
   output logic                 hit_o
);

   logic [MAX_SRC-1:0] req_ext;
   pick_t              pick;

   always_comb begin
      req_ext             = '0;
      req_ext[N_SRC-1:0]  = req_i;
      pick                = next_rr(req_ext, last_i, N_SRC);
   end

   assign grant_o = pick.idx;
   assign hit_o   = pick.hit;

endmodule

// File: rtl/rr_fifo_merger.sv
// Merges N FWFT sources into one FWFT 32-bit stream with round-robin,
// burst-limited grants and a single output register.
module rr_fifo_merger
   import rr_fifo_merger_pkg::*;
#(
   parameter int unsigned N_SRC     = 4,
   parameter int unsigned MAX_BURST = 16
) (
   input logic              BUS_CLK,
   input logic              RST,
   rr_fifo_merger_if.master bus
);

   localparam int unsigned          BURST_W   = $clog2(MAX_BURST + 1);
   localparam logic [BURST_W-1:0]   LAST_BEAT = BURST_W'(MAX_BURST - 1);
   localparam logic [SRC_IDX_W-1:0] LAST_RST  = SRC_IDX_W'(N_SRC - 1);

   state_e               state_q;
   logic [SRC_IDX_W-1:0] cur_src_q;
   logic [SRC_IDX_W-1:0] last_q;
   logic [BURST_W-1:0]   burst_q;

   logic [DATA_W-1:0]    data_q,       data_d;
   logic                 empty_q,      empty_d;
   logic [31:0]          word_count_q, word_count_d;
   logic                 rd_err_q,     rd_err_d;

   logic [SRC_IDX_W-1:0] pick_idx;
   logic                 pick_hit;
   logic [MAX_SRC-1:0]   src_empty_ext;
   logic                 cur_empty;
   logic                 out_free;
   logic                 pop;
   logic                 end_grant;
   logic [DATA_W-1:0]    sel_data;
   logic [N_SRC-1:0]     src_read;

   rr_pick #(
      .N_SRC (N_SRC)
   ) u_pick (
      .req_i   (~bus.SRC_EMPTY),
      .last_i  (last_q),
      .grant_o (pick_idx),
      .hit_o   (pick_hit)
   );

   // Out-of-range indices read as empty, so a bad grant can never pop.
   always_comb begin
      src_empty_ext             = '1;
      src_empty_ext[N_SRC-1:0]  = bus.SRC_EMPTY;
      cur_empty                 = src_empty_ext[cur_src_q];
      out_free                  = empty_q | bus.FIFO_READ_NEXT_IN;
      pop                       = (state_q == GRANT) && out_free && !cur_empty && !RST;
      end_grant                 = (pop && (burst_q == LAST_BEAT)) || (out_free && cur_empty);
   end

   always_comb begin
      sel_data = '0;
      src_read = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (cur_src_q == SRC_IDX_W'(i)) begin
            sel_data    = bus.SRC_DATA[DATA_W*i +: DATA_W];
            src_read[i] = pop;
         end
      end
   end

   always_ff @(posedge BUS_CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         cur_src_q <= '0;
         last_q    <= LAST_RST;
         burst_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (pick_hit) begin
                  cur_src_q <= pick_idx;
                  burst_q   <= '0;
                  state_q   <= GRANT;
               end
            end
            GRANT: begin
               if (pop) begin
                  burst_q <= burst_q + BURST_W'(1);
               end
               if (end_grant) begin
                  last_q  <= cur_src_q;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      data_d       = data_q;
      empty_d      = empty_q;
      word_count_d = word_count_q;
      rd_err_d     = rd_err_q;
      if (pop) begin
         data_d  = sel_data;
         empty_d = 1'b0;
      end else if (bus.FIFO_READ_NEXT_IN) begin
         empty_d = 1'b1;
      end
      if (bus.FIFO_READ_NEXT_IN && !empty_q && (word_count_q != '1)) begin
         word_count_d = word_count_q + 32'd1;
      end
      if (bus.FIFO_READ_NEXT_IN && empty_q) begin
         rd_err_d = 1'b1;
      end
   end

   always_ff @(posedge BUS_CLK) begin
      if (RST) begin
         data_q       <= '0;
         empty_q      <= 1'b1;
         word_count_q <= '0;
         rd_err_q     <= 1'b0;
      end else begin
         data_q       <= data_d;
         empty_q      <= empty_d;
         word_count_q <= word_count_d;
         rd_err_q     <= rd_err_d;
      end
   end

   assign bus.SRC_READ       = src_read;
   assign bus.FIFO_EMPTY_OUT = empty_q;
   assign bus.FIFO_DATA      = data_q;
   assign bus.CUR_SRC        = cur_src_q;
   assign bus.WORD_COUNT     = word_count_q;
   assign bus.READ_ERROR     = rd_err_q;

endmodule

// File: tb/tb_rr_fifo_merger.sv
// Scoreboard bench for rr_fifo_merger: source queues feed the DUT, popped
// words are expected back in order at the consumer side.
module tb_rr_fifo_merger;
   import rr_fifo_merger_pkg::*;

   localparam int unsigned N  = 4;
   localparam int unsigned MB = 4;

   logic BUS_CLK = 1'b0;
   logic RST;

   rr_fifo_merger_if #(.N_SRC(N)) bus ();

   rr_fifo_merger #(
      .N_SRC     (N),
      .MAX_BURST (MB)
   ) dut (
      .BUS_CLK (BUS_CLK),
      .RST     (RST),
      .bus     (bus.master)
   );

   always #5 BUS_CLK = ~BUS_CLK;

   int                checks = 0;
   int                errors = 0;
   logic [DATA_W-1:0] srcq [N][$];
   logic [DATA_W-1:0] expq [$];
   logic [N-1:0]      refill;
   int unsigned       seq = 0;

   logic              obs_empty;
   logic [DATA_W-1:0] obs_data;
   logic [N-1:0]      obs_read;
   logic [3:0]        obs_cur;

   function automatic logic [DATA_W-1:0] make_word(input int i);
      logic [DATA_W-1:0] w;
      w   = {8'hA0 + 8'(i), 24'(seq)};
      seq = seq + 1;
      return w;
   endfunction

   task automatic drive_srcs();
      for (int i = 0; i < N; i++) begin
         if (refill[i] && srcq[i].size() == 0) srcq[i].push_back(make_word(i));
         if (srcq[i].size() != 0) begin
            bus.SRC_EMPTY[i]          = 1'b0;
            bus.SRC_DATA[32*i +: 32]  = srcq[i][0];
         end else begin
            bus.SRC_EMPTY[i]          = 1'b1;
            bus.SRC_DATA[32*i +: 32]  = 32'hDEAD_0000 | 32'(i);
         end
      end
   endtask

   // One clock: drive at negedge, sample 1 ns later, apply pops after posedge.
   task automatic cycle();
      logic [DATA_W-1:0] w;
      drive_srcs();
      #1;
      obs_empty = bus.FIFO_EMPTY_OUT;
      obs_data  = bus.FIFO_DATA;
      obs_read  = bus.SRC_READ;
      obs_cur   = bus.CUR_SRC;
      checks++;
      if ($countones(obs_read) > 1 || (obs_read & bus.SRC_EMPTY) != '0) begin
         errors++;
         $display("FAIL src_read_legal: SRC_READ=%b SRC_EMPTY=%b required one-hot/zero on non-empty", obs_read, bus.SRC_EMPTY);
      end
      if (bus.FIFO_READ_NEXT_IN && !obs_empty) begin
         checks++;
         if (expq.size() == 0) begin
            errors++;
            $display("FAIL sb_extra_word: got %h required no word", obs_data);
         end else begin
            w = expq.pop_front();
            if (obs_data !== w) begin
               errors++;
               $display("FAIL sb_data: got %h required %h", obs_data, w);
            end
         end
      end
      @(posedge BUS_CLK);
      for (int i = 0; i < N; i++) begin
         if (obs_read[i] && srcq[i].size() != 0) expq.push_back(srcq[i].pop_front());
      end
      if (RST) expq.delete();
      @(negedge BUS_CLK);
   endtask

   task automatic do_reset();
      for (int i = 0; i < N; i++) srcq[i].delete();
      expq.delete();
      refill                = '0;
      bus.FIFO_READ_NEXT_IN = 1'b0;
      RST                   = 1'b1;
      cycle();
      cycle();
      RST = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      drive_srcs();
      #1;
      checks += 6;
      if (bus.FIFO_EMPTY_OUT !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b required 1", bus.FIFO_EMPTY_OUT); end
      if (bus.FIFO_DATA !== 32'h0) begin errors++; $display("FAIL rst_data: got %h required 0", bus.FIFO_DATA); end
      if (bus.CUR_SRC !== 4'd0) begin errors++; $display("FAIL rst_cur_src: got %0d required 0", bus.CUR_SRC); end
      if (bus.WORD_COUNT !== 32'h0) begin errors++; $display("FAIL rst_word_count: got %h required 0", bus.WORD_COUNT); end
      if (bus.READ_ERROR !== 1'b0) begin errors++; $display("FAIL rst_read_error: got %b required 0", bus.READ_ERROR); end
      if (bus.SRC_READ !== '0) begin errors++; $display("FAIL rst_src_read: got %b required 0", bus.SRC_READ); end
      @(negedge BUS_CLK);
   endtask

   task automatic test_single_source();
      logic [DATA_W-1:0] wa, wb, wc;
      logic [DATA_W-1:0] dat [6];
      logic              emp [6];
      do_reset();
      bus.FIFO_READ_NEXT_IN = 1'b1;
      wa = make_word(2);
      wb = make_word(2);
      wc = make_word(2);
      srcq[2].push_back(wa);
      srcq[2].push_back(wb);
      srcq[2].push_back(wc);
      for (int k = 0; k < 6; k++) begin
         cycle();
         dat[k] = obs_data;
         emp[k] = obs_empty;
      end
      checks += 7;
      if (emp[0] !== 1'b1 || emp[1] !== 1'b1) begin errors++; $display("FAIL single_latency: empty c0=%b c1=%b required 1 1", emp[0], emp[1]); end
      if (emp[2] !== 1'b0 || dat[2] !== wa) begin errors++; $display("FAIL single_word_a: got %h empty=%b required %h", dat[2], emp[2], wa); end
      if (emp[3] !== 1'b0 || dat[3] !== wb) begin errors++; $display("FAIL single_word_b: got %h empty=%b required %h", dat[3], emp[3], wb); end
      if (emp[4] !== 1'b0 || dat[4] !== wc) begin errors++; $display("FAIL single_word_c: got %h empty=%b required %h", dat[4], emp[4], wc); end
      if (emp[5] !== 1'b1) begin errors++; $display("FAIL single_empty_after: got %b required 1", emp[5]); end
      if (bus.WORD_COUNT !== 32'd3) begin errors++; $display("FAIL single_word_count: got %0d required 3", bus.WORD_COUNT); end
      if (expq.size() != 0) begin errors++; $display("FAIL single_sb_left: got %0d words required 0", expq.size()); end
   endtask

   task automatic test_burst();
      logic [7:0] tr [24];
      logic [7:0] pat [15];
      int         f;
      pat = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hEE,
              8'h01, 8'h01, 8'h01, 8'h01, 8'hEE,
              8'h00, 8'h00, 8'h00, 8'h00, 8'hEE};
      do_reset();
      bus.FIFO_READ_NEXT_IN = 1'b1;
      refill = 4'b0011;
      for (int k = 0; k < 24; k++) begin
         cycle();
         tr[k] = obs_empty ? 8'hEE : (obs_data[31:24] - 8'hA0);
      end
      f = -1;
      for (int k = 0; k < 6; k++) if (f < 0 && tr[k] != 8'hEE) f = k;
      checks++;
      if (f < 0) begin
         errors++;
         $display("FAIL burst_start: got no output in 6 cycles required first word");
      end else begin
         for (int j = 0; j < 15; j++) begin
            checks++;
            if (tr[f+j] !== pat[j]) begin
               errors++;
               $display("FAIL burst_seq[%0d]: got %h required %h (EE=empty)", j, tr[f+j], pat[j]);
            end
         end
      end
      refill = '0;
   endtask

   task automatic test_stall();
      logic [DATA_W-1:0] w0;
      do_reset();
      bus.FIFO_READ_NEXT_IN = 1'b0;
      w0 = make_word(1);
      srcq[1].push_back(w0);
      for (int k = 0; k < 4; k++) srcq[1].push_back(make_word(1));
      for (int k = 0; k < 10; k++) begin
         cycle();
         if (k >= 2) begin
            checks++;
            if (obs_empty !== 1'b0 || obs_data !== w0 || obs_read !== '0) begin
               errors++;
               $display("FAIL stall_hold[%0d]: data=%h empty=%b read=%b required %h 0 0", k, obs_data, obs_empty, obs_read, w0);
            end
         end
      end
      bus.FIFO_READ_NEXT_IN = 1'b1;
      for (int k = 0; k < 20; k++) cycle();
      checks += 2;
      if (expq.size() != 0 || srcq[1].size() != 0) begin
         errors++;
         $display("FAIL stall_drain: got %0d/%0d words left required 0/0", expq.size(), srcq[1].size());
      end
      if (bus.WORD_COUNT !== 32'd5) begin errors++; $display("FAIL stall_word_count: got %0d required 5", bus.WORD_COUNT); end
   endtask

   task automatic test_read_error();
      do_reset();
      cycle();
      checks++;
      if (bus.READ_ERROR !== 1'b0) begin errors++; $display("FAIL rderr_initial: got %b required 0", bus.READ_ERROR); end
      bus.FIFO_READ_NEXT_IN = 1'b1;
      cycle();
      bus.FIFO_READ_NEXT_IN = 1'b0;
      cycle();
      checks += 3;
      if (bus.READ_ERROR !== 1'b1) begin errors++; $display("FAIL rderr_set: got %b required 1", bus.READ_ERROR); end
      if (bus.WORD_COUNT !== 32'd0) begin errors++; $display("FAIL rderr_count: got %0d required 0", bus.WORD_COUNT); end
      if (bus.FIFO_EMPTY_OUT !== 1'b1) begin errors++; $display("FAIL rderr_empty: got %b required 1", bus.FIFO_EMPTY_OUT); end
      for (int k = 0; k < 3; k++) cycle();
      checks++;
      if (bus.READ_ERROR !== 1'b1) begin errors++; $display("FAIL rderr_sticky: got %b required 1", bus.READ_ERROR); end
      do_reset();
      checks++;
      if (bus.READ_ERROR !== 1'b0) begin errors++; $display("FAIL rderr_clear: got %b required 0", bus.READ_ERROR); end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      bus.FIFO_READ_NEXT_IN = 1'b1;
      for (int k = 0; k < 6; k++) srcq[3].push_back(make_word(3));
      cycle();
      cycle();
      checks++;
      if (obs_read !== 4'b1000) begin errors++; $display("FAIL mid_first_pop: got %b required 1000", obs_read); end
      srcq[1].push_back(make_word(1));
      srcq[1].push_back(make_word(1));
      RST = 1'b1;
      cycle();
      RST = 1'b0;
      checks++;
      if (obs_read !== '0) begin errors++; $display("FAIL mid_rst_cycle_read: got %b required 0", obs_read); end
      cycle();
      checks += 3;
      if (obs_empty !== 1'b1) begin errors++; $display("FAIL mid_after_empty: got %b required 1", obs_empty); end
      if (obs_read !== '0) begin errors++; $display("FAIL mid_after_read: got %b required 0", obs_read); end
      if (bus.WORD_COUNT !== 32'd0) begin errors++; $display("FAIL mid_after_count: got %0d required 0", bus.WORD_COUNT); end
      cycle();
      checks += 2;
      if (obs_cur !== 4'd1) begin errors++; $display("FAIL mid_regrant_src: got %0d required 1", obs_cur); end
      if (obs_read !== 4'b0010) begin errors++; $display("FAIL mid_regrant_read: got %b required 0010", obs_read); end
      for (int k = 0; k < 20; k++) cycle();
      checks++;
      if (expq.size() != 0 || srcq[1].size() != 0 || srcq[3].size() != 0) begin
         errors++;
         $display("FAIL mid_drain: got %0d/%0d/%0d words left required 0/0/0", expq.size(), srcq[1].size(), srcq[3].size());
      end
   endtask

   task automatic test_saturation();
      do_reset();
      force dut.word_count_q = 32'hFFFF_FFFE;
      #1;
      release dut.word_count_q;
      checks++;
      if (bus.WORD_COUNT !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sat_preload: got %h required fffffffe", bus.WORD_COUNT); end
      @(negedge BUS_CLK);
      bus.FIFO_READ_NEXT_IN = 1'b1;
      for (int k = 0; k < 3; k++) srcq[0].push_back(make_word(0));
      for (int k = 0; k < 10; k++) cycle();
      checks += 2;
      if (bus.WORD_COUNT !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_count: got %h required ffffffff", bus.WORD_COUNT); end
      if (expq.size() != 0 || srcq[0].size() != 0) begin
         errors++;
         $display("FAIL sat_drain: got %0d/%0d words left required 0/0", expq.size(), srcq[0].size());
      end
   endtask

   initial begin
      RST                   = 1'b1;
      refill                = '0;
      bus.FIFO_READ_NEXT_IN = 1'b0;
      bus.SRC_EMPTY         = '1;
      bus.SRC_DATA          = '0;
      @(negedge BUS_CLK);
      test_reset();
      test_single_source();
      test_burst();
      test_stall();
      test_read_error();
      test_reset_mid_burst();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
